bk_cskip_pipe: RTL

//  Parametrised, pipelined carry-skip adder/subtractor built from BLK-bit Brent-Kung blocks.

---
 rtl/bk_cskip_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bk_cskip_pipe.sv
// Pipelined carry-skip adder/subtractor built from Brent-Kung blocks; each stage resolves
// BLK_PER_STAGE blocks and passes its carry plus the unconsumed operand bits downstream.
module bk_cskip_pipe #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned BLK           = 4,
  parameter int unsigned BLK_PER_STAGE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       sum,
  output logic                   cout,
  output logic                   ovf,
  output logic [WIDTH/BLK-1:0]   skip_mask
);

  localparam int unsigned NBLK = WIDTH / BLK;
  localparam int unsigned LAT  = NBLK / BLK_PER_STAGE;
  localparam int unsigned SW   = BLK * BLK_PER_STAGE;

  if ((WIDTH % BLK) != 0 || (NBLK % BLK_PER_STAGE) != 0 || BLK < 2 ||
      (BLK & (BLK - 1)) != 0) begin : g_param_err
    $error("bk_cskip_pipe: illegal WIDTH/BLK/BLK_PER_STAGE combination");
  end

  // Brent-Kung prefix over one block; returns {carry_out, sum}.
  function automatic logic [BLK:0] bk_add(input logic [BLK-1:0] x, input logic [BLK-1:0] y,
                                          input logic ci);
    logic [BLK-1:0] g, p, p0, s;
    logic [BLK:0]   c;
    g  = x & y;
    p  = x ^ y;
    p0 = p;
    for (int d = 1; d < BLK; d = d * 2) begin
      for (int i = 2 * d - 1; i < BLK; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    for (int d = BLK / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < BLK; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    c[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      c[i+1] = g[i] | (p[i] & ci);
    end
    s = p0 ^ c[BLK-1:0];
    return {c[BLK], s};
  endfunction

  logic [LAT-1:0]  v_q;
  logic [LAT:0]    en;
  logic [WIDTH-1:0] a_q    [LAT];
  logic [WIDTH-1:0] bb_q   [LAT];
  logic [WIDTH-1:0] sum_q  [LAT];
  logic [NBLK-1:0]  skip_q [LAT];
  logic [LAT-1:0]   c_q;
  logic             ovf_q;

  logic [WIDTH-1:0] src_a    [LAT];
  logic [WIDTH-1:0] src_bb   [LAT];
  logic [WIDTH-1:0] src_sum  [LAT];
  logic [NBLK-1:0]  src_skip [LAT];
  logic [LAT-1:0]   src_c;
  logic [LAT-1:0]   src_v;
  logic [WIDTH-1:0] a_d    [LAT];
  logic [WIDTH-1:0] bb_d   [LAT];
  logic [WIDTH-1:0] sum_d  [LAT];
  logic [NBLK-1:0]  skip_d [LAT];
  logic [LAT-1:0]   c_d;
  logic             ovf_d;

  // A stage may load when empty or when everything downstream of it moves this cycle.
  always_comb begin
    en      = '0;
    en[LAT] = out_ready;
    for (int k = LAT - 1; k >= 0; k--) begin
      en[k] = ~v_q[k] | en[k+1];
    end
  end

  assign in_ready = en[0];

  always_comb begin
    logic [BLK-1:0] x, y;
    logic [BLK:0]   r;
    logic           carry, gp;
    int unsigned    blk;
    x     = '0;
    y     = '0;
    r     = '0;
    carry = 1'b0;
    gp    = 1'b0;
    blk   = 0;

    src_a[0]    = a;
    src_bb[0]   = sub ? ~b : b;
    src_sum[0]  = '0;
    src_skip[0] = '0;
    src_c[0]    = cin ^ sub;
    src_v[0]    = in_valid;
    for (int k = 1; k < LAT; k++) begin
      src_a[k]    = a_q[k-1];
      src_bb[k]   = bb_q[k-1];
      src_sum[k]  = sum_q[k-1];
      src_skip[k] = skip_q[k-1];
      src_c[k]    = c_q[k-1];
      src_v[k]    = v_q[k-1];
    end

    for (int k = 0; k < LAT; k++) begin
      carry     = src_c[k];
      sum_d[k]  = src_sum[k];
      skip_d[k] = src_skip[k];
      for (int j = 0; j < BLK_PER_STAGE; j++) begin
        blk   = k * BLK_PER_STAGE + j;
        x     = src_a[k][j*BLK +: BLK];
        y     = src_bb[k][j*BLK +: BLK];
        gp    = &(x ^ y);
        r     = bk_add(x, y, carry);
        sum_d[k][blk*BLK +: BLK] = r[BLK-1:0];
        skip_d[k][blk] = gp;
        carry = gp ? carry : r[BLK];
      end
      c_d[k]  = carry;
      // Consumed operand bits are shifted out; later stages always work on the low SW bits.
      a_d[k]  = src_a[k] >> SW;
      bb_d[k] = src_bb[k] >> SW;
    end

    ovf_d = src_a[LAT-1][SW-1] ^ src_bb[LAT-1][SW-1] ^ sum_d[LAT-1][WIDTH-1] ^ c_d[LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        a_q[k]    <= '0;
        bb_q[k]   <= '0;
        sum_q[k]  <= '0;
        skip_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (flush) begin
          v_q[k] <= 1'b0;
        end else if (en[k]) begin
          v_q[k] <= src_v[k];
        end
        if (en[k] && src_v[k]) begin
          a_q[k]    <= a_d[k];
          bb_q[k]   <= bb_d[k];
          sum_q[k]  <= sum_d[k];
          skip_q[k] <= skip_d[k];
          c_q[k]    <= c_d[k];
        end
      end
      if (en[LAT-1] && src_v[LAT-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign sum       = sum_q[LAT-1];
  assign cout      = c_q[LAT-1];
  assign ovf       = ovf_q;
  assign skip_mask = skip_q[LAT-1];

endmodule
